// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM ramp controller.
package pwm_pkg;
  localparam int WIDTH = 16;
  typedef logic [WIDTH-1:0] pwm_word_t;
  localparam pwm_word_t RESET_RANGE = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, ARM, RAMP} pwm_ctrl_state_t;
endpackage

// File: rtl/pwm_step_sat.sv
// pwm_step_sat: one saturating step of value toward tgt; a zero step jumps straight to tgt.
module pwm_step_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] next
);
  logic [W:0] sum, lim;
  assign sum = {1'b0, value} + {1'b0, step};
  assign lim = {1'b0, tgt} + {1'b0, step};
  assign next = (step == '0 || value == tgt) ? tgt
              : (value < tgt) ? ((sum > {1'b0, tgt}) ? tgt : sum[W-1:0])
              : (({1'b0, value} < lim) ? tgt : value - step);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: accepts ramp commands and steps one PWM channel's duty toward a target
// once per PWM period, so every duty/range change lands on a period boundary.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = pwm_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_RANGE = WIDTH'(pwm_pkg::RESET_RANGE)
) (
  input  logic             pwm_clk,
  input  logic             pwm_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_en,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [WIDTH-1:0] cmd_range,
  input  logic             pwm_period,
  output logic [WIDTH-1:0] pwm_value,
  output logic [WIDTH-1:0] pwm_range,
  output logic             pwm_en,
  output logic             busy,
  output logic             done
);
  pwm_ctrl_state_t state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, step_q, step_d, range_q, range_d;
  logic [WIDTH-1:0] pwm_value_q, pwm_value_d, pwm_range_q, pwm_range_d, nxt;
  logic en_q, en_d, pwm_en_q, pwm_en_d, done_q, done_d;
  logic cmd_ready_q, cmd_ready_d, busy_q, busy_d;

  pwm_step_sat #(.W(WIDTH)) u_step (
    .value(pwm_value_q),
    .tgt  (tgt_q),
    .step (step_q),
    .next (nxt)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    range_d     = range_q;
    en_d        = en_q;
    pwm_value_d = pwm_value_q;
    pwm_range_d = pwm_range_q;
    pwm_en_d    = pwm_en_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        tgt_d   = cmd_en ? ((cmd_target > cmd_range) ? cmd_range : cmd_target) : '0;
        step_d  = cmd_step;
        range_d = cmd_range;
        en_d    = cmd_en;
        state_d = ARM;
      end
      // A disabled channel has no running period to protect, so it is reconfigured at once.
      ARM: if (!pwm_en_q) begin
        pwm_range_d = range_q;
        pwm_value_d = '0;
        pwm_en_d    = en_q;
        done_d      = !en_q;
        state_d     = en_q ? RAMP : IDLE;
      end else if (pwm_period) begin
        pwm_range_d = range_q;
        pwm_value_d = (pwm_value_q > range_q) ? range_q : pwm_value_q;
        state_d     = RAMP;
      end
      RAMP: if (pwm_period) begin
        pwm_value_d = nxt;
        if (nxt == tgt_q) begin
          done_d   = 1'b1;
          pwm_en_d = en_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge pwm_clk or negedge pwm_reset) begin
    if (!pwm_reset) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      step_q      <= '0;
      range_q     <= '0;
      en_q        <= 1'b0;
      pwm_value_q <= '0;
      pwm_range_q <= RESET_RANGE;
      pwm_en_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      range_q     <= range_d;
      en_q        <= en_d;
      pwm_value_q <= pwm_value_d;
      pwm_range_q <= pwm_range_d;
      pwm_en_q    <= pwm_en_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pwm_value = pwm_value_q;
  assign pwm_range = pwm_range_q;
  assign pwm_en    = pwm_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed ramp scenarios with hand-computed duty sequences.
module tb_pwm_ramp_ctrl;
  logic        pwm_clk = 1'b0, pwm_reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_en = 1'b0, pwm_period = 1'b0;
  logic [15:0] cmd_target = '0, cmd_step = '0, cmd_range = '0;
  logic        cmd_ready, pwm_en, busy, done;
  logic [15:0] pwm_value, pwm_range;
  int tests = 0, fails = 0;

  pwm_ramp_ctrl dut (
    .pwm_clk(pwm_clk), .pwm_reset(pwm_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_en(cmd_en),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_range(cmd_range),
    .pwm_period(pwm_period), .pwm_value(pwm_value), .pwm_range(pwm_range),
    .pwm_en(pwm_en), .busy(busy), .done(done)
  );

  always #5 pwm_clk = ~pwm_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic strobe();
    pwm_period = 1'b1;
    tick();
    pwm_period = 1'b0;
  endtask

  task automatic send(input logic en, input logic [15:0] tg, input logic [15:0] st, input logic [15:0] rg);
    cmd_valid = 1'b1; cmd_en = en; cmd_target = tg; cmd_step = st; cmd_range = rg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_vd(input string tag, input logic [15:0] v, input logic d);
    chk({tag, "_value"}, 32'(pwm_value), 32'(v));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  initial begin
    tick(); tick();
    chk("rst_value", 32'(pwm_value), 0);
    chk("rst_range", 32'(pwm_range), 32'hFFFF);
    chk("rst_en", 32'(pwm_en), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    pwm_reset = 1'b1;
    pwm_period = 1'b1;
    tick(); tick();
    pwm_period = 1'b0;
    chk("idle_ready", 32'(cmd_ready), 1);
    chk("idle_range", 32'(pwm_range), 32'hFFFF);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_value", 32'(pwm_value), 0);

    // Up-ramp from disabled
    send(1'b1, 16'd50, 16'd10, 16'd100);
    chk("acc_ready", 32'(cmd_ready), 0);
    chk("acc_busy", 32'(busy), 1);
    chk("acc_en", 32'(pwm_en), 0);
    tick();
    chk("arm_en", 32'(pwm_en), 1);
    chk("arm_range", 32'(pwm_range), 100);
    chk("arm_value", 32'(pwm_value), 0);
    tick();
    chk("nostrobe_value", 32'(pwm_value), 0);
    strobe(); chk_vd("up1", 16'd10, 1'b0);
    strobe(); chk_vd("up2", 16'd20, 1'b0);
    strobe(); chk_vd("up3", 16'd30, 1'b0);
    strobe(); chk_vd("up4", 16'd40, 1'b0);
    strobe(); chk_vd("up5", 16'd50, 1'b1);
    tick();
    chk("up_done_pulse", 32'(done), 0);
    chk("up_ready", 32'(cmd_ready), 1);
    chk("up_busy", 32'(busy), 0);

    // Down to 45, then overshoot-saturated up-step to 50
    send(1'b1, 16'd45, 16'd5, 16'd100);
    strobe(); chk_vd("ov_arm", 16'd50, 1'b0);
    strobe(); chk_vd("ov_45", 16'd45, 1'b1);
    tick();
    send(1'b1, 16'd50, 16'd10, 16'd100);
    strobe(); chk_vd("ov_arm2", 16'd45, 1'b0);
    strobe(); chk_vd("ov_sat", 16'd50, 1'b1);
    tick();

    // Down-ramp 50 -> 20 by 7
    send(1'b1, 16'd20, 16'd7, 16'd100);
    strobe(); chk_vd("dn_arm", 16'd50, 1'b0);
    strobe(); chk_vd("dn1", 16'd43, 1'b0);
    strobe(); chk_vd("dn2", 16'd36, 1'b0);
    strobe(); chk_vd("dn3", 16'd29, 1'b0);
    strobe(); chk_vd("dn4", 16'd22, 1'b0);
    strobe(); chk_vd("dn5", 16'd20, 1'b1);
    tick();

    // Disable with jump to 0
    send(1'b0, 16'd77, 16'd0, 16'd100);
    strobe(); chk_vd("off_arm", 16'd20, 1'b0);
    chk("off_arm_en", 32'(pwm_en), 1);
    strobe(); chk_vd("off", 16'd0, 1'b1);
    chk("off_en", 32'(pwm_en), 0);
    tick();

    // Disable while already disabled completes in ARM
    send(1'b0, 16'd5, 16'd1, 16'd90);
    tick();
    chk("off2_done", 32'(done), 1);
    chk("off2_range", 32'(pwm_range), 90);
    chk("off2_en", 32'(pwm_en), 0);
    chk("off2_ready", 32'(cmd_ready), 1);
    tick();

    // Target clamps to range
    send(1'b1, 16'd300, 16'd100, 16'd200);
    tick();
    chk("cl_range", 32'(pwm_range), 200);
    strobe(); chk_vd("cl1", 16'd100, 1'b0);
    strobe(); chk_vd("cl2", 16'd200, 1'b1);
    tick();
    send(1'b1, 16'd150, 16'd0, 16'd200);
    strobe(); strobe(); chk_vd("jump150", 16'd150, 1'b1);
    tick();

    // Range shrink clamps running value at the ARM strobe
    send(1'b1, 16'd100, 16'd10, 16'd120);
    strobe();
    chk_vd("shr_arm", 16'd120, 1'b0);
    chk("shr_range", 32'(pwm_range), 120);
    strobe(); chk_vd("shr1", 16'd110, 1'b0);
    strobe(); chk_vd("shr2", 16'd100, 1'b1);
    tick();

    // Reset mid-RAMP at value 30, with a command held off
    send(1'b1, 16'd30, 16'd0, 16'd120);
    strobe(); strobe(); chk_vd("pre30", 16'd30, 1'b1);
    tick();
    send(1'b1, 16'd80, 16'd10, 16'd120);
    strobe(); chk_vd("rr_arm", 16'd30, 1'b0);
    cmd_valid = 1'b1; cmd_target = 16'd999; cmd_step = 16'd1; cmd_range = 16'd999;
    tick(); tick();
    chk("hold_ready", 32'(cmd_ready), 0);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_range", 32'(pwm_range), 120);
    chk_vd("hold", 16'd30, 1'b0);
    #1 pwm_reset = 1'b0;
    #1;
    chk("arst_value", 32'(pwm_value), 0);
    chk("arst_range", 32'(pwm_range), 32'hFFFF);
    chk("arst_en", 32'(pwm_en), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    cmd_valid = 1'b0;
    tick();
    pwm_reset = 1'b1;
    tick();
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencing controller for one PWM_UNIT channel. It accepts ramp commands over a valid/ready handshake and drives the channel's pwm_value, pwm_range and pwm_en. The duty value steps toward a target once per PWM period, using the unit's pwm_period end-of-period strobe, so every update is glitch-free. The block sits between the register/command layer and PWM_UNIT.

Parameters:
- WIDTH, 16, bit width of value, range and step.
- RESET_RANGE, 16'hFFFF, pwm_range value driven out of reset.

Ports:
- pwm_clk  input  1  single clock for the whole block.
- pwm_reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_en  input  1  1 = ramp to target and stay enabled; 0 = ramp to 0, then disable.
- cmd_target  input  WIDTH  requested duty value.
- cmd_step  input  WIDTH  increment per period; 0 = jump directly to target.
- cmd_range  input  WIDTH  period range to apply.
- pwm_period  input  1  one-cycle strobe from PWM_UNIT at the end of each period.
- pwm_value  output  WIDTH  duty value to PWM_UNIT.
- pwm_range  output  WIDTH  range to PWM_UNIT.
- pwm_en  output  1  enable to PWM_UNIT.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, pwm_reset=0): state=IDLE, pwm_value=0, pwm_range=RESET_RANGE, pwm_en=0, cmd_ready=1, busy=0, done=0, latched fields=0.
- Reset asserted mid-operation aborts immediately; no done pulse.
- All outputs are registered.
- States are IDLE, ARM and RAMP.

IDLE:
- cmd_ready=1.
- On cmd_valid && cmd_ready:
  - latch tgt = cmd_en ? min(cmd_target, cmd_range) : 0;
  - latch step, range and en;
  - go to ARM. cmd_ready=0 from the next cycle.

ARM:
- If pwm_en==0: apply pwm_range=range and pwm_value=0 this cycle (no period wait). pwm_en is set to the latched en, except that cmd_en=0 with pwm_en=0 completes immediately: done=1, go to IDLE.
- If pwm_en==1: wait for a pwm_period strobe. On the strobe:
  - pwm_range=range;
  - pwm_value=min(pwm_value, range), clamped to the new range;
  - go to RAMP.
- pwm_period sampled in the acceptance cycle is ignored.

RAMP:
- On each pwm_period strobe, pwm_value moves one step toward tgt with saturation:
  - up: next = (value+step > tgt) ? tgt : value+step, computed at WIDTH+1 bits (no wrap);
  - down: next = (value < tgt+step) ? tgt : value-step, with no underflow;
  - step==0: next = tgt.
- On the same edge where next==tgt:
  - done<=1 for one cycle;
  - go to IDLE;
  - if the latched en==0, pwm_en<=0 on that edge as well.
- If value already equals tgt on entry to RAMP, completion happens at the first strobe.

Boundary and simultaneity rules:
- cmd_valid while busy is held off by cmd_ready=0; there is no queuing.
- pwm_period is never acted on outside ARM and RAMP.
- A strobe arriving in the same cycle as the ARM→RAMP transition is consumed by ARM only.

Latency:
- Acceptance to ARM: 1 cycle.
- A ramp of N steps completes on the Nth strobe after ARM exits.

Decomposition:
- pwm_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARM, RAMP} pwm_ctrl_state_t;
  - typedef logic [WIDTH-1:0] pwm_word_t, with WIDTH as a package localparam defaulting to 16;
  - localparam RESET_RANGE.
- One sub-module, pwm_step_sat: combinational saturating step toward target (inputs value, tgt, step; output next). It is reusable by future multi-channel sequencers.

Test Plan:
- Reset release, then idle: all outputs at reset values; cmd_ready=1, pwm_range=16'hFFFF.
- From disabled, cmd(en=1, range=100, target=50, step=10):
  - pwm_en=1 and pwm_range=100 one cycle after ARM;
  - pwm_value goes 10, 20, 30, 40, 50 on 5 successive strobes;
  - done pulses on the 5th strobe edge.
- Overshoot: value=45 with target=50, step=10 → value=50 on the next strobe, done.
- Down-ramp:
  - value=50, cmd(target=20, step=7) → 43, 36, 29, 22, 20.
  - Then cmd(en=0, step=0) → value=0 and pwm_en=0 on the first RAMP strobe, done.
- Range shrink and clamp:
  - cmd_target=300 with cmd_range=200 → tgt clamps to 200.
  - Running value=150 with cmd_range=120 → pwm_value=120 at the ARM strobe.
- Reset asserted mid-RAMP (value=30): outputs return to reset values asynchronously with no done. cmd_valid held during RAMP is not accepted until IDLE.
